// File: rtl/simd_wb_arbiter.sv
// Round-robin arbiter sharing the scalar SGPR/VCC write port among NUM_SIMD SIMD units.
// A granted request is latched and replayed as a VCC write, an SGPR write, or both in that order.
module simd_wb_arbiter #(
  parameter int NUM_SIMD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SIMD-1:0]       simd_req,
  input  logic [NUM_SIMD-1:0]       simd_vcc_wr_en,
  input  logic [NUM_SIMD-1:0]       simd_sgpr_wr_en,
  input  logic [NUM_SIMD-1:0][5:0]  simd_wfid,
  input  logic [NUM_SIMD-1:0][8:0]  simd_sgpr_addr,
  input  logic [NUM_SIMD-1:0][63:0] simd_data,
  output logic [NUM_SIMD-1:0]       simd_grant,
  input  logic                      wr_ready,
  output logic                      vcc_wr_en,
  output logic                      sgpr_wr_en,
  output logic [5:0]                wr_wfid,
  output logic [8:0]                wr_sgpr_addr,
  output logic [63:0]               wr_data,
  output logic                      busy
);
  localparam int IDXW = $clog2(NUM_SIMD);

  typedef enum logic [1:0] {IDLE, WR_VCC, WR_SGPR} state_e;

  typedef struct packed {
    logic        vcc;
    logic        sgpr;
    logic [5:0]  wfid;
    logic [8:0]  addr;
    logic [63:0] data;
  } wb_req_t;

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  wb_req_t         lat_q, lat_d;

  logic [IDXW-1:0] sel, cand;
  logic            found, grant_en;

  // Search upward from rr_ptr+1; the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    cand  = '0;
    for (int k = 1; k <= NUM_SIMD; k++) begin
      cand = IDXW'((int'(rr_ptr_q) + k) % NUM_SIMD);
      if (!found && simd_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Gated by rst so no grant pulse can escape while the block is held in reset.
  assign grant_en   = rst && (state_q == IDLE) && found;
  assign simd_grant = grant_en ? (NUM_SIMD'(1) << sel) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    lat_d    = lat_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          lat_d.vcc  = simd_vcc_wr_en[sel];
          lat_d.sgpr = simd_sgpr_wr_en[sel];
          lat_d.wfid = simd_wfid[sel];
          lat_d.addr = simd_sgpr_addr[sel];
          lat_d.data = simd_data[sel];
          rr_ptr_d   = sel;
          if (simd_vcc_wr_en[sel])       state_d = WR_VCC;
          else if (simd_sgpr_wr_en[sel]) state_d = WR_SGPR;
          else                           state_d = IDLE;
        end
      end
      WR_VCC:  if (wr_ready) state_d = lat_q.sgpr ? WR_SGPR : IDLE;
      WR_SGPR: if (wr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDXW'(NUM_SIMD - 1);
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lat_q    <= lat_d;
    end
  end

  // Enables come from registered state only, never from wr_ready.
  assign vcc_wr_en    = (state_q == WR_VCC);
  assign sgpr_wr_en   = (state_q == WR_SGPR);
  assign busy         = (state_q != IDLE);
  assign wr_wfid      = lat_q.wfid;
  assign wr_sgpr_addr = lat_q.addr;
  assign wr_data      = lat_q.data;
endmodule

// File: tb/tb_simd_wb_arbiter.sv
// Directed bench for simd_wb_arbiter: grant timing checked inline, write beats
// checked against a queue of expected writes filled when each request is driven.
module tb_simd_wb_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      simd_req, simd_vcc_wr_en, simd_sgpr_wr_en, simd_grant;
  logic [N-1:0][5:0] simd_wfid;
  logic [N-1:0][8:0] simd_sgpr_addr;
  logic [N-1:0][63:0] simd_data;
  logic              wr_ready, vcc_wr_en, sgpr_wr_en, busy;
  logic [5:0]        wr_wfid;
  logic [8:0]        wr_sgpr_addr;
  logic [63:0]       wr_data;

  typedef struct {
    logic        is_vcc;
    logic [5:0]  wfid;
    logic [8:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  simd_wb_arbiter #(.NUM_SIMD(N)) dut (
    .clk(clk), .rst(rst),
    .simd_req(simd_req), .simd_vcc_wr_en(simd_vcc_wr_en), .simd_sgpr_wr_en(simd_sgpr_wr_en),
    .simd_wfid(simd_wfid), .simd_sgpr_addr(simd_sgpr_addr), .simd_data(simd_data),
    .simd_grant(simd_grant), .wr_ready(wr_ready),
    .vcc_wr_en(vcc_wr_en), .sgpr_wr_en(sgpr_wr_en), .wr_wfid(wr_wfid),
    .wr_sgpr_addr(wr_sgpr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input int i, input logic v, input logic s, input logic [5:0] w,
                     input logic [8:0] a, input logic [63:0] d, input bit push);
    simd_req[i]        = 1'b1;
    simd_vcc_wr_en[i]  = v;
    simd_sgpr_wr_en[i] = s;
    simd_wfid[i]       = w;
    simd_sgpr_addr[i]  = a;
    simd_data[i]       = d;
    if (push && v) exp_q.push_back('{1'b1, w, a, d});
    if (push && s) exp_q.push_back('{1'b0, w, a, d});
  endtask

  task automatic chk_wr(input string tag, input logic v, input logic s, input logic b);
    check({tag, "_vcc"},  vcc_wr_en, v);
    check({tag, "_sgpr"}, sgpr_wr_en, s);
    check({tag, "_busy"}, busy, b);
  endtask

  // Scoreboard: every accepted write beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst && wr_ready && (vcc_wr_en || sgpr_wr_en)) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_kind", vcc_wr_en, e.is_vcc);
        check("sb_data", wr_data, e.data);
        check("sb_wfid", wr_wfid, e.wfid);
        if (!e.is_vcc) check("sb_addr", wr_sgpr_addr, e.addr);
      end
    end
  end

  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    simd_req = '0; simd_vcc_wr_en = '0; simd_sgpr_wr_en = '0;
    simd_wfid = '0; simd_sgpr_addr = '0; simd_data = '0;
    wr_ready = 1'b1;

    // Reset state, with a request present that must not be granted
    simd_req[0] = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    check("rst_grant", simd_grant, 4'b0000);
    chk_wr("rst", 1'b0, 1'b0, 1'b0);
    check("rst_data", wr_data, 64'h0);
    check("rst_wfid", wr_wfid, 6'd0);
    cyc(); simd_req = '0;
    cyc(); rst = 1'b1;

    // Single VCC write from SIMD2
    cyc(); req(2, 1'b1, 1'b0, 6'd5, 9'h000, 64'hFFFF_0000_1234_5678, 1'b1);
    smp(); check("svcc_grant", simd_grant, 4'b0100); check("svcc_busy0", busy, 1'b0);
    cyc(); simd_req[2] = 1'b0;
    smp(); chk_wr("svcc_w", 1'b1, 1'b0, 1'b1);
    check("svcc_data", wr_data, 64'hFFFF_0000_1234_5678); check("svcc_wfid", wr_wfid, 6'd5);
    cyc(); smp(); chk_wr("svcc_end", 1'b0, 1'b0, 1'b0);

    // Dual write from SIMD0
    cyc(); req(0, 1'b1, 1'b1, 6'd7, 9'h010, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    smp(); check("dual_grant", simd_grant, 4'b0001);
    cyc(); simd_req[0] = 1'b0;
    smp(); chk_wr("dual_v", 1'b1, 1'b0, 1'b1);
    cyc(); smp(); chk_wr("dual_s", 1'b0, 1'b1, 1'b1);
    check("dual_addr", wr_sgpr_addr, 9'h010); check("dual_data", wr_data, 64'hA5A5_5A5A_0F0F_F0F0);
    cyc(); smp(); chk_wr("dual_end", 1'b0, 1'b0, 1'b0);

    // Null request from SIMD1, then an immediate grant to SIMD3
    cyc(); req(1, 1'b0, 1'b0, 6'd9, 9'h000, 64'h1111, 1'b1);
    smp(); check("null_grant", simd_grant, 4'b0010);
    cyc(); simd_req[1] = 1'b0; req(3, 1'b0, 1'b1, 6'd12, 9'h1A5, 64'h2222_3333, 1'b1);
    smp(); chk_wr("null_n1", 1'b0, 1'b0, 1'b0); check("null_next_grant", simd_grant, 4'b1000);
    cyc(); simd_req[3] = 1'b0;
    smp(); chk_wr("null_s", 1'b0, 1'b1, 1'b1); check("null_addr", wr_sgpr_addr, 9'h1A5);
    cyc(); smp(); check("null_end_busy", busy, 1'b0);

    // Back-pressure during WR_VCC with SIMD3 pending
    cyc(); req(2, 1'b1, 1'b1, 6'd21, 9'h0F0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    req(3, 1'b0, 1'b1, 6'd22, 9'h111, 64'h0123_4567_89AB_CDEF, 1'b1);
    smp(); check("bp_grant", simd_grant, 4'b0100);
    cyc(); simd_req[2] = 1'b0; wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      smp();
      chk_wr("bp_hold", 1'b1, 1'b0, 1'b1);
      check("bp_data", wr_data, 64'hDEAD_BEEF_CAFE_F00D);
      check("bp_nogrant", simd_grant, 4'b0000);
    end
    cyc(); wr_ready = 1'b1;
    smp(); check("bp_rel_vcc", vcc_wr_en, 1'b1); check("bp_rel_nogrant", simd_grant, 4'b0000);
    cyc(); smp(); chk_wr("bp_s", 1'b0, 1'b1, 1'b1); check("bp_s_nogrant", simd_grant, 4'b0000);
    check("bp_addr", wr_sgpr_addr, 9'h0F0);
    cyc(); smp(); check("bp_next_grant", simd_grant, 4'b1000);
    cyc(); simd_req[3] = 1'b0;
    smp(); chk_wr("bp_s3", 1'b0, 1'b1, 1'b1);
    cyc(); smp(); check("bp_end_busy", busy, 1'b0);

    // Round-robin contention from reset
    cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) req(i, 1'b1, 1'b0, 6'(30 + i), 9'h000, 64'h5000 + 64'(i), 1'b1);
    smp(); check("rr_rst_grant", simd_grant, 4'b0000);
    cyc(); rst = 1'b1;
    smp();
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", simd_grant, 4'b0001 << ord[k]);
      cyc(); simd_req[ord[k]] = 1'b0;
      if (k == 1) req(0, 1'b1, 1'b0, 6'd40, 9'h000, 64'h7777_0000, 1'b1);
      smp(); check("rr_gap_grant", simd_grant, 4'b0000); check("rr_vcc", vcc_wr_en, 1'b1);
      cyc(); smp();
    end
    check("rr_end_busy", busy, 1'b0);

    // Reset asserted during a stalled WR_SGPR
    cyc(); req(1, 1'b1, 1'b1, 6'd50, 9'h0AB, 64'h9999_8888_7777_6666, 1'b1);
    smp(); check("mr_grant", simd_grant, 4'b0010);
    cyc(); simd_req[1] = 1'b0;
    smp(); check("mr_vcc", vcc_wr_en, 1'b1);
    cyc(); wr_ready = 1'b0;
    smp(); chk_wr("mr_s", 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_wr("mr_rst", 1'b0, 1'b0, 1'b0);
    check("mr_data", wr_data, 64'h0); check("mr_wfid", wr_wfid, 6'd0);
    check("mr_addr", wr_sgpr_addr, 9'h000);
    exp_q.delete();
    for (int i = 0; i < N; i++) req(i, 1'b0, 1'b1, 6'(60 + i), 9'(9'h100 + i), 64'hC000 + 64'(i), i == 0);
    #1 check("mr_rst_grant", simd_grant, 4'b0000);
    cyc(); wr_ready = 1'b1; rst = 1'b1;
    smp(); check("mr_first_grant", simd_grant, 4'b0001);
    cyc(); simd_req = '0;
    smp(); chk_wr("mr_post_s", 1'b0, 1'b1, 1'b1);
    cyc(); smp(); check("mr_end_busy", busy, 1'b0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/simd_wb_arbiter.md
# simd_wb_arbiter

Shares the single scalar write port (SGPR file plus VCC) among `NUM_SIMD` SIMD units. Each SIMD presents a completed ALU result with the `vcc_wr_en` and `sgpr_wr_en` flags produced by its instruction decoder. The arbiter picks one requester round-robin, latches its payload and sequences the writes. When both flags are set it issues a VCC write and then an SGPR write, and it stalls on port back-pressure. It sits between the SIMD writeback stages and the SGPR/VCC register-file write interface.

## Interface
Parameters
- `NUM_SIMD`, default 4: number of requesting SIMD units, range 2–8.

Ports (request buses are packed, SIMD i in slice i)
- `clk`  in  1  — clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `simd_req`  in  NUM_SIMD  — request valid, held until granted.
- `simd_vcc_wr_en`  in  NUM_SIMD  — request carries a VCC write.
- `simd_sgpr_wr_en`  in  NUM_SIMD  — request carries an SGPR write.
- `simd_wfid`  in  6*NUM_SIMD  — wavefront id.
- `simd_sgpr_addr`  in  9*NUM_SIMD  — SGPR destination address.
- `simd_data`  in  64*NUM_SIMD  — 64-bit result (per-lane compare mask or SGPR pair).
- `simd_grant`  out  NUM_SIMD  — one-hot, one-cycle acceptance pulse.
- `wr_ready`  in  1  — write port accepts this cycle.
- `vcc_wr_en`  out  1  — VCC write valid.
- `sgpr_wr_en`  out  1  — SGPR write valid.
- `wr_wfid`  out  6  — wavefront id of the current write.
- `wr_sgpr_addr`  out  9  — SGPR address.
- `wr_data`  out  64  — write data.
- `busy`  out  1  — high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, WR_VCC, WR_SGPR.
- In IDLE, when any `simd_req` is high:
  - Select the first requester searching upward from `rr_ptr+1` (mod NUM_SIMD).
  - Assert its `simd_grant` combinationally that cycle.
  - On the clock edge, latch its wfid, addr, data and both flags, and set `rr_ptr` to that index.
- Next state after a grant:
  - WR_VCC if the vcc flag is set.
  - Otherwise WR_SGPR if the sgpr flag is set.
  - Otherwise IDLE: the request is consumed and dropped, and no write is issued.
- WR_VCC:
  - `vcc_wr_en`=1, `sgpr_wr_en`=0; `wr_data`/`wr_wfid` come from the latch.
  - On an edge with `wr_ready`=1, go to WR_SGPR if the sgpr flag is latched, else IDLE.
- WR_SGPR:
  - `sgpr_wr_en`=1, `vcc_wr_en`=0; `wr_sgpr_addr` comes from the latch.
  - On an edge with `wr_ready`=1, go to IDLE.
- While `wr_ready`=0, all write outputs hold stable and no grant is issued.
- Grants occur only in IDLE; latched payload is never overwritten outside IDLE.
- Requesters not granted keep `simd_req` high. The arbiter has no timeout, but round-robin guarantees each requester is served within NUM_SIMD grants.
- In IDLE, `wr_*` outputs are don't-care with both enables at 0. The implementation drives them from the latch.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE, `rr_ptr`=NUM_SIMD-1 (SIMD0 has first priority);
  - latch and all outputs 0, `simd_grant`=0, `busy`=0.
- Request seen in IDLE at cycle N: grant in cycle N, first write valid in cycle N+1.
- Write enables are decoded from the registered state only; they never depend combinationally on `wr_ready`.
- Transaction length, with no stall:
  - single write: 2 cycles (grant + 1 write);
  - dual write: 3 cycles;
  - each `wr_ready`=0 cycle adds 1.
- Sustained throughput with no stall: one single-write grant every 2 cycles.
- If a request arrives in the same cycle the last write completes, it is not granted until the next cycle (IDLE).
- Reset asserted mid-transaction: the pending write is abandoned. No enable may be high after reset asserts; the in-flight requester has already been granted and is not retried.

## Test plan
- **Single VCC write:** SIMD2 requests with vcc=1, sgpr=0, data=64'hFFFF_0000_1234_5678, wfid=5.
  - `simd_grant`=4'b0100 in cycle N.
  - Cycle N+1: `vcc_wr_en`=1, `wr_data` equal to the input, `wr_wfid`=5.
  - Cycle N+2: `busy`=0.
- **Dual write:** SIMD0 requests with vcc=1, sgpr=1, addr=9'h010, `wr_ready`=1.
  - N+1: VCC write.
  - N+2: SGPR write, addr 0x010, same data.
  - N+3: IDLE.
- **Round-robin contention:** all four `simd_req` held high from reset; each request drops one cycle after its grant.
  - Grant order is SIMD0, SIMD1, SIMD2, SIMD3, spaced 2 cycles apart.
  - Re-asserting SIMD0 after SIMD1 is granted does not make it beat SIMD2.
- **Back-pressure:** with a dual write in flight, hold `wr_ready`=0 for 3 cycles during WR_VCC.
  - `vcc_wr_en` and `wr_data` stay stable.
  - No new grant while the other requests are pending.
  - The SGPR write follows the first `wr_ready`=1 edge.
- **Null request:** SIMD1 requests with both flags 0.
  - Grant pulses.
  - No write enable is asserted at any point.
  - FSM stays or returns to IDLE; next grant is possible at N+1.
- **Reset mid-operation:** assert `rst`=0 during WR_SGPR with `wr_ready`=0.
  - All outputs go to 0 immediately.
  - After release, the first grant goes to SIMD0 when all SIMDs request.
